if_fetch_unit: RTL and testbench

Instruction-fetch stage that sits directly upstream of the instruction decoder. It holds the 64-bit PC and issues word fetches to instruction memory. Returned 32-bit instructions are buffered in an in-order queue and presented to the decoder with a valid/ready handshake. A taken-branch redirect flushes the queue, discards in-flight responses and restarts fetch at the target.

---
 rtl/if_fetch_unit.sv | 117 +++++++++++
 tb/tb_if_fetch_unit.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage. Holds the PC, issues word fetches,
// buffers returned instructions in an in-order queue for the decoder and
// discards stale responses after a taken-branch redirect.
module if_fetch_unit #(
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                QDEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       instruction,
    output logic [ADDR_W-1:0] inst_pc
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);
    localparam logic [CW+1:0] QD_L = QDEPTH[CW+1:0];

    logic [ADDR_W-1:0] pc;

    // instruction queue: {word, pc}
    logic [31:0]       q_word [QDEPTH];
    logic [ADDR_W-1:0] q_pc   [QDEPTH];
    logic [PW-1:0]     q_head;
    logic [PW-1:0]     q_tail;
    logic [CW-1:0]     count;

    // PCs of live outstanding requests, oldest first
    logic [ADDR_W-1:0] pf_pc [QDEPTH];
    logic [PW-1:0]     pf_head;
    logic [PW-1:0]     pf_tail;

    logic [CW-1:0]     inflight;
    logic [CW-1:0]     drop;

    logic [CW+1:0]     credit_used;
    logic              issue;
    logic              resp_drop;
    logic              resp_take;
    logic              deq;
    logic [ADDR_W-1:0] target;

    assign credit_used = {2'b00, inflight} + {2'b00, drop} + {2'b00, count};
    assign imem_req    = rst_n & ~redirect & (credit_used < QD_L);
    assign imem_addr   = pc;
    assign issue       = imem_req;

    // A response with nothing outstanding is a protocol violation and is ignored.
    assign resp_drop   = imem_rvalid & (drop != '0);
    assign resp_take   = imem_rvalid & (drop == '0) & (inflight != '0);

    assign inst_valid  = rst_n & (count != '0);
    assign deq         = inst_valid & inst_ready;
    assign instruction = q_word[q_head];
    assign inst_pc     = q_pc[q_head];
    assign target      = {redirect_pc[ADDR_W-1:2], 2'b00};

    // Control state: PC, pointers and credit counters; redirect overrides all.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            count    <= '0;
            inflight <= '0;
            drop     <= '0;
            q_head   <= '0;
            q_tail   <= '0;
            pf_head  <= '0;
            pf_tail  <= '0;
        end else if (redirect) begin
            // Every live request becomes a discard credit; a response
            // arriving this cycle retires one of them either way.
            pc       <= target;
            count    <= '0;
            inflight <= '0;
            drop     <= drop + inflight - CW'(resp_drop | resp_take);
            q_head   <= '0;
            q_tail   <= '0;
            pf_head  <= '0;
            pf_tail  <= '0;
        end else begin
            if (issue) begin
                pc      <= pc + ADDR_W'(4);
                pf_tail <= pf_tail + PW'(1);
            end
            if (resp_take) begin
                q_tail  <= q_tail + PW'(1);
                pf_head <= pf_head + PW'(1);
            end
            if (deq) begin
                q_head <= q_head + PW'(1);
            end
            inflight <= inflight + CW'(issue) - CW'(resp_take);
            drop     <= drop - CW'(resp_drop);
            count    <= count + CW'(resp_take) - CW'(deq);
        end
    end

    // Storage arrays: record issued PCs and capture accepted responses.
    always_ff @(posedge clk) begin
        if (issue) begin
            pf_pc[pf_tail] <= pc;
        end
        if (resp_take) begin
            q_word[q_tail] <= imem_rdata;
            q_pc[q_tail]   <= pf_pc[pf_head];
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: randomized and directed checks of if_fetch_unit against
// an in-order memory model and a stream-level model of the decoder's view.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // main DUT (RESET_PC = 0)
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] instruction;
    logic [63:0] inst_pc;

    // wrap DUT (RESET_PC near the top of the address space)
    logic        rst2_n = 1'b0;
    logic        req2;
    logic [63:0] addr2;
    logic        rvalid2 = 1'b0;
    logic [31:0] rdata2 = '0;
    logic        redirect2 = 1'b0;
    logic [63:0] rpc2 = '0;
    logic        valid2;
    logic        ready2 = 1'b1;
    logic [31:0] instr2;
    logic [63:0] pc2;

    if_fetch_unit #(.ADDR_W(64), .RESET_PC(64'h0), .QDEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect(redirect),
        .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .instruction(instruction), .inst_pc(inst_pc)
    );

    if_fetch_unit #(.ADDR_W(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFF8), .QDEPTH(4)) dut_wrap (
        .clk(clk), .rst_n(rst2_n), .imem_req(req2), .imem_addr(addr2),
        .imem_rvalid(rvalid2), .imem_rdata(rdata2), .redirect(redirect2),
        .redirect_pc(rpc2), .inst_valid(valid2), .inst_ready(ready2),
        .instruction(instr2), .inst_pc(pc2)
    );

    int compared   = 0;
    int mismatched = 0;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] word_of(input logic [63:0] a);
        return 32'hF840_0000 + a[31:0];
    endfunction

    // memory model: in-order, per-request latency within [lat_min, lat_max]
    typedef struct {
        logic [63:0] addr;
        int unsigned due;
    } mreq_t;
    mreq_t       mq[$];
    int unsigned lat_min  = 1;
    int unsigned lat_max  = 1;
    int unsigned last_due = 0;

    // decoder-view model: after reset/redirect to T, PCs are T, T+4, ...
    logic [63:0] exp_pc    = '0;
    logic [63:0] exp_fetch = '0;
    int          issued_live   = 0;
    int          consumed_live = 0;
    int          live          = 0;
    int          hs_count      = 0;
    logic        prev_hold = 1'b0;
    logic [63:0] prev_pc   = '0;
    logic [31:0] prev_word = '0;

    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            mq.delete();
            imem_rvalid   = 1'b0;
            imem_rdata    = '0;
            exp_pc        = '0;
            exp_fetch     = '0;
            issued_live   = 0;
            consumed_live = 0;
            prev_hold     = 1'b0;
            last_due      = cyc;
            compared++;
            if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
                mismatched++;
                $display("FAIL reset_outputs: req=%b valid=%b, required 0/0", imem_req, inst_valid);
            end
        end else begin
            live = issued_live - consumed_live;
            if (mq.size() > 0 && mq[0].due == cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = word_of(mq[0].addr);
                void'(mq.pop_front());
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = $urandom;
            end
            if (prev_hold) begin
                compared++;
                if (inst_valid !== 1'b1 || inst_pc !== prev_pc || instruction !== prev_word) begin
                    mismatched++;
                    $display("FAIL hold_stable: valid=%b pc=%h word=%h, required 1 pc=%h word=%h",
                             inst_valid, inst_pc, instruction, prev_pc, prev_word);
                end
            end
            if (inst_valid === 1'b1 && inst_ready === 1'b1) begin
                compared++;
                if (inst_pc !== exp_pc || instruction !== word_of(exp_pc)) begin
                    mismatched++;
                    $display("FAIL handshake: pc=%h word=%h, required pc=%h word=%h",
                             inst_pc, instruction, exp_pc, word_of(exp_pc));
                end
                exp_pc = exp_pc + 64'd4;
                consumed_live++;
                hs_count++;
            end
            prev_hold = (inst_valid === 1'b1) && !inst_ready && !redirect;
            prev_pc   = inst_pc;
            prev_word = instruction;
            if (redirect) begin
                compared++;
                if (imem_req !== 1'b0) begin
                    mismatched++;
                    $display("FAIL req_on_redirect: req=%b, required 0", imem_req);
                end
                exp_pc        = {redirect_pc[63:2], 2'b00};
                exp_fetch     = {redirect_pc[63:2], 2'b00};
                issued_live   = 0;
                consumed_live = 0;
            end else if (imem_req === 1'b1) begin
                mreq_t r;
                int unsigned d;
                compared++;
                if (imem_addr !== exp_fetch || live >= 4) begin
                    mismatched++;
                    $display("FAIL fetch_addr: addr=%h live=%0d, required addr=%h live<4",
                             imem_addr, live, exp_fetch);
                end
                d = cyc + $urandom_range(lat_max, lat_min);
                if (d <= last_due) d = last_due + 1;
                last_due = d;
                r.addr = imem_addr;
                r.due  = d;
                mq.push_back(r);
                exp_fetch = exp_fetch + 64'd4;
                issued_live++;
            end
        end
    end

    // wrap-instance memory: fixed latency of one cycle
    logic        pend2  = 1'b0;
    logic [31:0] pdata2 = '0;
    always @(negedge clk) begin
        #1;
        if (!rst2_n) begin
            rvalid2 = 1'b0;
            pend2   = 1'b0;
        end else begin
            rvalid2 = pend2;
            rdata2  = pdata2;
            pend2   = req2;
            pdata2  = word_of(addr2);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n    = 1'b0;
        redirect = 1'b0;
        tick(2);
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 64'h500;
        repeat (3) begin
            @(negedge clk);
            #2;
            compared++;
            if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
                mismatched++;
                $display("FAIL test_reset_hold: req=%b valid=%b, required 0/0", imem_req, inst_valid);
            end
        end
        @(negedge clk);
        rst_n    = 1'b1;
        redirect = 1'b0;
        #2;
        compared++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
            mismatched++;
            $display("FAIL test_reset_first_req: req=%b addr=%h, required 1 addr=0", imem_req, imem_addr);
        end
    endtask

    task automatic test_stream();
        int h0;
        lat_min    = 1;
        lat_max    = 1;
        inst_ready = 1'b1;
        tick(10);
        h0 = hs_count;
        tick(20);
        compared++;
        if (hs_count - h0 != 20) begin
            mismatched++;
            $display("FAIL test_stream_rate: handshakes=%0d, required 20", hs_count - h0);
        end
    endtask

    task automatic test_backpressure();
        int h0;
        lat_min = 1;
        lat_max = 1;
        reset_pulse();
        rst_n      = 1'b1;
        inst_ready = 1'b0;
        tick(10);
        #2;
        compared++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b1 || inst_pc !== 64'h0 || instruction !== word_of(64'h0)) begin
            mismatched++;
            $display("FAIL test_backpressure_full: req=%b valid=%b pc=%h word=%h, required 0 1 pc=0 word=%h",
                     imem_req, inst_valid, inst_pc, instruction, word_of(64'h0));
        end
        @(negedge clk);
        inst_ready = 1'b1;
        h0 = hs_count;
        tick(4);
        compared++;
        if (hs_count - h0 != 4) begin
            mismatched++;
            $display("FAIL test_backpressure_drain: handshakes=%0d, required 4", hs_count - h0);
        end
    endtask

    task automatic wait_first_valid(input string name, input logic [63:0] want);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            #2;
            if (inst_valid === 1'b1) seen = 1'b1;
        end
        compared++;
        if (!seen || inst_pc !== want || instruction !== word_of(want)) begin
            mismatched++;
            $display("FAIL %s: seen=%b pc=%h word=%h, required pc=%h word=%h",
                     name, seen, inst_pc, instruction, want, word_of(want));
        end
    endtask

    task automatic test_redirect_inflight();
        lat_min    = 3;
        lat_max    = 3;
        inst_ready = 1'b1;
        reset_pulse();
        rst_n = 1'b1;
        tick(2);
        redirect    = 1'b1;
        redirect_pc = 64'h100;
        @(negedge clk);
        redirect = 1'b0;
        wait_first_valid("test_redirect_inflight", 64'h100);
        tick(10);
    endtask

    task automatic test_redirect_collide();
        lat_min    = 1;
        lat_max    = 1;
        inst_ready = 1'b1;
        reset_pulse();
        rst_n = 1'b1;
        tick(8);
        redirect    = 1'b1;
        redirect_pc = 64'h203;
        #2;
        compared++;
        if (inst_valid !== 1'b1 || imem_rvalid !== 1'b1) begin
            mismatched++;
            $display("FAIL test_collide_setup: valid=%b rvalid=%b, required 1/1", inst_valid, imem_rvalid);
        end
        @(negedge clk);
        redirect = 1'b0;
        wait_first_valid("test_redirect_collide", 64'h200);
        tick(10);
    endtask

    task automatic test_random();
        int h0;
        lat_min = 1;
        lat_max = 4;
        h0 = hs_count;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            inst_ready  = ($urandom_range(9, 0) < 7);
            redirect    = ($urandom_range(99, 0) < 3);
            redirect_pc = ($urandom_range(3, 0) == 0) ? {32'hFFFF_FFFF, 28'hFFFF_FFF, 4'($urandom)}
                                                      : {$urandom, $urandom};
        end
        @(negedge clk);
        redirect   = 1'b0;
        inst_ready = 1'b1;
        tick(20);
        compared++;
        if (hs_count - h0 < 500) begin
            mismatched++;
            $display("FAIL test_random_progress: handshakes=%0d, required >=500", hs_count - h0);
        end
    endtask

    task automatic test_wrap();
        logic [63:0] want [4];
        logic [63:0] got_pc [4];
        logic [31:0] got_w  [4];
        int n = 0;
        want[0] = 64'hFFFF_FFFF_FFFF_FFF8;
        want[1] = 64'hFFFF_FFFF_FFFF_FFFC;
        want[2] = 64'h0;
        want[3] = 64'h4;
        @(negedge clk);
        rst2_n = 1'b0;
        tick(3);
        rst2_n = 1'b1;
        for (int i = 0; i < 30 && n < 4; i++) begin
            #2;
            if (valid2 === 1'b1) begin
                got_pc[n] = pc2;
                got_w[n]  = instr2;
                n++;
            end
            @(negedge clk);
        end
        compared++;
        if (n != 4) begin
            mismatched++;
            $display("FAIL test_wrap_count: got=%0d, required 4", n);
        end
        for (int i = 0; i < n; i++) begin
            compared++;
            if (got_pc[i] !== want[i] || got_w[i] !== word_of(want[i])) begin
                mismatched++;
                $display("FAIL test_wrap_%0d: pc=%h word=%h, required pc=%h word=%h",
                         i, got_pc[i], got_w[i], want[i], word_of(want[i]));
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_collide();
        test_random();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
